// File: rtl/matmul_acc_top.sv
// matmul_acc_top: N x N unsigned matrix-multiply engine with MMIO control
// registers and a row-wide DMA port. Runs OUT = A*B, or OUT += A*B when
// acc_mode is set. One MAC per cycle, then one write-back per output element.
module matmul_acc_top #(
   parameter int MUL_SIZE      = 8,
   parameter int ELEM_WIDTH    = 8,
   parameter int MMIO_WIDTH    = 32,
   parameter int MMIO_ADDRBITS = 32,
   parameter int DMA_WIDTH     = MUL_SIZE * ELEM_WIDTH,
   parameter int DMA_ADDRBITS  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mmio_w_req,
   input  logic [MMIO_ADDRBITS-1:0] mmio_w_addr,
   input  logic [MMIO_WIDTH-1:0]    mmio_w_data,
   input  logic                     mmio_r_req,
   input  logic [MMIO_ADDRBITS-1:0] mmio_r_addr,
   output logic [MMIO_WIDTH-1:0]    mmio_r_data,
   input  logic                     dma_w_req,
   input  logic [DMA_ADDRBITS-1:0]  dma_w_addr,
   input  logic [DMA_WIDTH-1:0]     dma_w_data,
   input  logic                     dma_r_req,
   input  logic [DMA_ADDRBITS-1:0]  dma_r_addr,
   output logic [DMA_WIDTH-1:0]     dma_r_data
);

   localparam int IDXW      = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;
   localparam int ROW_BYTES = DMA_WIDTH / 8;
   localparam int WIN_BYTES = MUL_SIZE * MUL_SIZE * ELEM_WIDTH / 8;

   localparam logic [DMA_ADDRBITS-1:0] OFF_INA = DMA_ADDRBITS'(32'h0004_0000);
   localparam logic [DMA_ADDRBITS-1:0] OFF_INB = DMA_ADDRBITS'(32'h0008_0000);
   localparam logic [DMA_ADDRBITS-1:0] OFF_OUT = DMA_ADDRBITS'(32'h000C_0000);

   localparam logic [MMIO_ADDRBITS-1:0] REG_N     = MMIO_ADDRBITS'(8'h00);
   localparam logic [MMIO_ADDRBITS-1:0] REG_CTRL  = MMIO_ADDRBITS'(8'h08);
   localparam logic [MMIO_ADDRBITS-1:0] REG_OFFA  = MMIO_ADDRBITS'(8'h10);
   localparam logic [MMIO_ADDRBITS-1:0] REG_OFFB  = MMIO_ADDRBITS'(8'h18);
   localparam logic [MMIO_ADDRBITS-1:0] REG_OFFO  = MMIO_ADDRBITS'(8'h20);
   localparam logic [MMIO_ADDRBITS-1:0] REG_COUNT = MMIO_ADDRBITS'(8'h28);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MUL_SIZE - 1);

   // Row memories, stored element-wise so the engine can address single elements.
   logic [ELEM_WIDTH-1:0] mem_a_r   [0:MUL_SIZE-1][0:MUL_SIZE-1];
   logic [ELEM_WIDTH-1:0] mem_b_r   [0:MUL_SIZE-1][0:MUL_SIZE-1];
   logic [ELEM_WIDTH-1:0] mem_out_r [0:MUL_SIZE-1][0:MUL_SIZE-1];

   logic [1:0]            state_r;
   logic                  running_r;
   logic                  acc_mode_r;
   logic                  done_r;
   logic                  err_r;
   logic [MMIO_WIDTH-1:0] count_r;
   logic [MMIO_WIDTH-1:0] run_cyc_r;
   logic [IDXW-1:0]       i_r;
   logic [IDXW-1:0]       j_r;
   logic [IDXW-1:0]       k_r;
   logic [ELEM_WIDTH-1:0] acc_r;

   logic                    w_hit_a_s, w_hit_b_s, w_hit_o_s, w_hit_any_s;
   logic [DMA_ADDRBITS-1:0] w_off_s, w_rel_s, w_row_full_s;
   logic [IDXW-1:0]         w_row_s;
   logic                    r_hit_o_s;
   logic [DMA_ADDRBITS-1:0] r_rel_s, r_row_full_s;
   logic [IDXW-1:0]         r_row_s;
   logic [DMA_WIDTH-1:0]    out_row_s;
   logic                    dma_wr_ok_s, dma_drop_s;
   logic                    ctrl_wr_s, start_s, abort_s;
   logic                    last_elem_s, fin_s, eng_we_s;
   logic [ELEM_WIDTH-1:0]   prod_s, acc_next_s, wb_val_s;
   logic [MMIO_WIDTH-1:0]   mmio_rd_s;
   logic                    unused_s;

   function automatic logic in_win(input logic [DMA_ADDRBITS-1:0] addr,
                                   input logic [DMA_ADDRBITS-1:0] off);
      return (addr >= off) && (addr < (off + DMA_ADDRBITS'(WIN_BYTES)));
   endfunction

   // DMA write window decode and row index.
   always_comb begin
      w_hit_a_s   = in_win(dma_w_addr, OFF_INA);
      w_hit_b_s   = in_win(dma_w_addr, OFF_INB);
      w_hit_o_s   = in_win(dma_w_addr, OFF_OUT);
      w_hit_any_s = w_hit_a_s | w_hit_b_s | w_hit_o_s;
      if (w_hit_a_s) begin
         w_off_s = OFF_INA;
      end else if (w_hit_b_s) begin
         w_off_s = OFF_INB;
      end else if (w_hit_o_s) begin
         w_off_s = OFF_OUT;
      end else begin
         w_off_s = {DMA_ADDRBITS{1'b0}};
      end
      w_rel_s      = dma_w_addr - w_off_s;
      w_row_full_s = w_rel_s / DMA_ADDRBITS'(ROW_BYTES);
      w_row_s      = w_row_full_s[IDXW-1:0];
      dma_wr_ok_s  = dma_w_req & w_hit_any_s & ~running_r;
      dma_drop_s   = dma_w_req & w_hit_any_s & running_r;
   end

   // DMA read decode: only the OUT window is readable.
   always_comb begin
      r_hit_o_s    = in_win(dma_r_addr, OFF_OUT);
      r_rel_s      = dma_r_addr - OFF_OUT;
      r_row_full_s = r_rel_s / DMA_ADDRBITS'(ROW_BYTES);
      r_row_s      = r_row_full_s[IDXW-1:0];
      out_row_s    = {DMA_WIDTH{1'b0}};
      for (int j = 0; j < MUL_SIZE; j++) begin
         out_row_s[j*ELEM_WIDTH +: ELEM_WIDTH] = mem_out_r[r_row_s][j];
      end
   end

   // Control decode and engine datapath.
   always_comb begin
      ctrl_wr_s   = mmio_w_req & (mmio_w_addr == REG_CTRL);
      start_s     = ctrl_wr_s & mmio_w_data[0] & ~running_r;
      abort_s     = ctrl_wr_s & ~mmio_w_data[0] & running_r;
      last_elem_s = (i_r == LAST_IDX) & (j_r == LAST_IDX);
      fin_s       = (state_r == ST_WB) & last_elem_s & ~abort_s;
      eng_we_s    = (state_r == ST_WB) & ~abort_s;
      prod_s      = mem_a_r[i_r][k_r] * mem_b_r[k_r][j_r];
      acc_next_s  = acc_r + prod_s;
      if (acc_mode_r) begin
         wb_val_s = acc_r + mem_out_r[i_r][j_r];
      end else begin
         wb_val_s = acc_r;
      end
   end

   // MMIO read multiplexer.
   always_comb begin
      case (mmio_r_addr)
         REG_N:     mmio_rd_s = MMIO_WIDTH'(MUL_SIZE);
         REG_CTRL:  mmio_rd_s = MMIO_WIDTH'({err_r, done_r, acc_mode_r, running_r});
         REG_OFFA:  mmio_rd_s = MMIO_WIDTH'(32'h0004_0000);
         REG_OFFB:  mmio_rd_s = MMIO_WIDTH'(32'h0008_0000);
         REG_OFFO:  mmio_rd_s = MMIO_WIDTH'(32'h000C_0000);
         REG_COUNT: mmio_rd_s = count_r;
         default:   mmio_rd_s = {MMIO_WIDTH{1'b0}};
      endcase
   end

   // Memory writes: DMA rows while idle, single OUT elements from the engine.
   always_ff @(posedge clk) begin
      if (dma_wr_ok_s && w_hit_a_s) begin
         for (int j = 0; j < MUL_SIZE; j++) begin
            mem_a_r[w_row_s][j] <= dma_w_data[j*ELEM_WIDTH +: ELEM_WIDTH];
         end
      end
      if (dma_wr_ok_s && w_hit_b_s) begin
         for (int j = 0; j < MUL_SIZE; j++) begin
            mem_b_r[w_row_s][j] <= dma_w_data[j*ELEM_WIDTH +: ELEM_WIDTH];
         end
      end
      if (dma_wr_ok_s && w_hit_o_s) begin
         for (int j = 0; j < MUL_SIZE; j++) begin
            mem_out_r[w_row_s][j] <= dma_w_data[j*ELEM_WIDTH +: ELEM_WIDTH];
         end
      end
      if (eng_we_s) begin
         mem_out_r[i_r][j_r] <= wb_val_s;
      end
   end

   // Control/status registers and the engine state machine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         running_r  <= 1'b0;
         acc_mode_r <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         count_r    <= {MMIO_WIDTH{1'b0}};
         run_cyc_r  <= {MMIO_WIDTH{1'b0}};
         i_r        <= {IDXW{1'b0}};
         j_r        <= {IDXW{1'b0}};
         k_r        <= {IDXW{1'b0}};
         acc_r      <= {ELEM_WIDTH{1'b0}};
      end else begin
         if (ctrl_wr_s && !running_r) begin
            acc_mode_r <= mmio_w_data[1];
         end
         // A dropped DMA write outranks a simultaneous clear request.
         if (dma_drop_s) begin
            err_r <= 1'b1;
         end else if (ctrl_wr_s && mmio_w_data[3]) begin
            err_r <= 1'b0;
         end
         if (start_s) begin
            done_r <= 1'b0;
         end else if (fin_s) begin
            done_r <= 1'b1;
         end else if (ctrl_wr_s && mmio_w_data[2]) begin
            done_r <= 1'b0;
         end
         if (fin_s) begin
            count_r <= run_cyc_r + MMIO_WIDTH'(1'b1);
         end
         case (state_r)
            ST_IDLE, ST_FIN: begin
               if (start_s) begin
                  state_r   <= ST_MAC;
                  running_r <= 1'b1;
                  run_cyc_r <= {MMIO_WIDTH{1'b0}};
                  i_r       <= {IDXW{1'b0}};
                  j_r       <= {IDXW{1'b0}};
                  k_r       <= {IDXW{1'b0}};
                  acc_r     <= {ELEM_WIDTH{1'b0}};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_MAC: begin
               if (abort_s) begin
                  state_r   <= ST_IDLE;
                  running_r <= 1'b0;
               end else begin
                  run_cyc_r <= run_cyc_r + MMIO_WIDTH'(1'b1);
                  acc_r     <= acc_next_s;
                  if (k_r == LAST_IDX) begin
                     k_r     <= {IDXW{1'b0}};
                     state_r <= ST_WB;
                  end else begin
                     k_r <= k_r + IDXW'(1'b1);
                  end
               end
            end
            ST_WB: begin
               if (abort_s) begin
                  state_r   <= ST_IDLE;
                  running_r <= 1'b0;
               end else begin
                  run_cyc_r <= run_cyc_r + MMIO_WIDTH'(1'b1);
                  acc_r     <= {ELEM_WIDTH{1'b0}};
                  if (last_elem_s) begin
                     state_r   <= ST_FIN;
                     running_r <= 1'b0;
                  end else begin
                     state_r <= ST_MAC;
                     if (j_r == LAST_IDX) begin
                        j_r <= {IDXW{1'b0}};
                        i_r <= i_r + IDXW'(1'b1);
                     end else begin
                        j_r <= j_r + IDXW'(1'b1);
                     end
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               running_r <= 1'b0;
            end
         endcase
      end
   end

   // Registered read ports; data holds until the next request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mmio_r_data <= {MMIO_WIDTH{1'b0}};
         dma_r_data  <= {DMA_WIDTH{1'b0}};
      end else begin
         if (mmio_r_req) begin
            mmio_r_data <= mmio_rd_s;
         end
         if (dma_r_req) begin
            dma_r_data <= r_hit_o_s ? out_row_s : {DMA_WIDTH{1'b0}};
         end
      end
   end

   // Address/data bits that carry no meaning for this block.
   assign unused_s = ^{mmio_w_data[MMIO_WIDTH-1:4],
                       w_row_full_s[DMA_ADDRBITS-1:IDXW],
                       r_row_full_s[DMA_ADDRBITS-1:IDXW]};

endmodule

// File: tb/tb_matmul_acc_top.sv
// Self-checking bench for matmul_acc_top (N=8, EW=8). Read expectations are
// queued when a read is issued and popped when the registered data appears.
module tb_matmul_acc_top;

   localparam logic [31:0] OFF_INA  = 32'h0004_0000;
   localparam logic [31:0] OFF_INB  = 32'h0008_0000;
   localparam logic [31:0] OFF_OUT  = 32'h000C_0000;
   localparam logic [31:0] REG_CTRL = 32'h0000_0008;
   localparam logic [31:0] REG_CNT  = 32'h0000_0028;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mmio_w_req = 1'b0;
   logic [31:0] mmio_w_addr = 32'h0;
   logic [31:0] mmio_w_data = 32'h0;
   logic        mmio_r_req = 1'b0;
   logic [31:0] mmio_r_addr = 32'h0;
   logic [31:0] mmio_r_data;
   logic        dma_w_req = 1'b0;
   logic [31:0] dma_w_addr = 32'h0;
   logic [63:0] dma_w_data = 64'h0;
   logic        dma_r_req = 1'b0;
   logic [31:0] dma_r_addr = 32'h0;
   logic [63:0] dma_r_data;

   logic [7:0]  ma [8][8];
   logic [7:0]  mb [8][8];
   logic [7:0]  mo [8][8];
   logic [63:0] sb_q [$];
   logic [63:0] exp_v;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   matmul_acc_top dut (
      .clk(clk), .rst(rst),
      .mmio_w_req(mmio_w_req), .mmio_w_addr(mmio_w_addr), .mmio_w_data(mmio_w_data),
      .mmio_r_req(mmio_r_req), .mmio_r_addr(mmio_r_addr), .mmio_r_data(mmio_r_data),
      .dma_w_req(dma_w_req), .dma_w_addr(dma_w_addr), .dma_w_data(dma_w_data),
      .dma_r_req(dma_r_req), .dma_r_addr(dma_r_addr), .dma_r_data(dma_r_data)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] pack_row(input int sel, input int r);
      logic [63:0] v;
      v = 64'h0;
      for (int c = 0; c < 8; c++) begin
         case (sel)
            0:       v[c*8 +: 8] = ma[r][c];
            1:       v[c*8 +: 8] = mb[r][c];
            default: v[c*8 +: 8] = mo[r][c];
         endcase
      end
      return v;
   endfunction

   // Reference model: recompute the first nelem output elements in row-major order.
   task automatic model_run(input logic accm, input int nelem);
      logic [7:0]  acc;
      logic [15:0] p;
      for (int e = 0; e < nelem; e++) begin
         acc = 8'h00;
         for (int k = 0; k < 8; k++) begin
            p   = ma[e/8][k] * mb[k][e%8];
            acc = acc + p[7:0];
         end
         mo[e/8][e%8] = accm ? (mo[e/8][e%8] + acc) : acc;
      end
   endtask

   task automatic dma_write_row(input logic [31:0] addr, input logic [63:0] data);
      dma_w_req  = 1'b1;
      dma_w_addr = addr;
      dma_w_data = data;
      @(negedge clk);
      dma_w_req  = 1'b0;
   endtask

   task automatic load_all();
      for (int r = 0; r < 8; r++) dma_write_row(OFF_INA + 32'(r*8), pack_row(0, r));
      for (int r = 0; r < 8; r++) dma_write_row(OFF_INB + 32'(r*8), pack_row(1, r));
      for (int r = 0; r < 8; r++) dma_write_row(OFF_OUT + 32'(r*8), pack_row(2, r));
   endtask

   task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
      mmio_w_req  = 1'b1;
      mmio_w_addr = addr;
      mmio_w_data = data;
      @(negedge clk);
      mmio_w_req  = 1'b0;
      mmio_w_data = 32'h0;
   endtask

   task automatic mmio_issue(input logic [31:0] addr, input logic [31:0] expv);
      mmio_r_req  = 1'b1;
      mmio_r_addr = addr;
      sb_q.push_back({32'h0, expv});
   endtask

   task automatic dma_issue(input logic [31:0] addr, input logic [63:0] expv);
      dma_r_req  = 1'b1;
      dma_r_addr = addr;
      sb_q.push_back(expv);
   endtask

   task automatic test_reset();
      logic [31:0] addrs [7];
      logic [31:0] exps  [7];
      addrs = '{32'h00, 32'h08, 32'h10, 32'h18, 32'h20, 32'h28, 32'h30};
      exps  = '{32'd8, 32'h0, 32'h0004_0000, 32'h0008_0000, 32'h000C_0000, 32'h0, 32'h0};
      repeat (2) @(negedge clk);
      total_cnt++;
      if (mmio_r_data !== 32'h0) $display("FAIL reset_mmio_r_data: got %h want 0", mmio_r_data);
      else pass_cnt++;
      total_cnt++;
      if (dma_r_data !== 64'h0) $display("FAIL reset_dma_r_data: got %h want 0", dma_r_data);
      else pass_cnt++;
      rst = 1'b0;
      for (int n = 0; n < 7; n++) begin
         mmio_issue(addrs[n], exps[n]);
         @(negedge clk);
         exp_v = sb_q.pop_front();
         total_cnt++;
         if ({32'h0, mmio_r_data} !== exp_v)
            $display("FAIL reset_reg_%0h: got %h want %h", addrs[n], mmio_r_data, exp_v);
         else pass_cnt++;
      end
      mmio_r_req = 1'b0;
   endtask

   task automatic test_identity();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
         ma[r][c] = (r == c) ? 8'd1 : 8'd0;
         mb[r][c] = 8'(r*8 + c);
         mo[r][c] = 8'hAA;
      end
      load_all();
      model_run(1'b0, 64);
      mmio_write(REG_CTRL, 32'h1);
      repeat (575) @(negedge clk);
      // Last write-back edge: still running before it, done right after it.
      mmio_issue(REG_CTRL, 32'h1);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL ident_ctrl_last_wb: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_issue(REG_CTRL, 32'h4);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL ident_ctrl_fin: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_issue(REG_CNT, 32'd576);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL ident_count: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_r_req = 1'b0;
      for (int r = 0; r < 8; r++) begin
         dma_issue(OFF_OUT + 32'(r*8), pack_row(2, r));
         @(negedge clk);
         exp_v = sb_q.pop_front();
         total_cnt++;
         if (dma_r_data !== exp_v) $display("FAIL ident_out_row%0d: got %h want %h", r, dma_r_data, exp_v);
         else pass_cnt++;
      end
      dma_issue(OFF_INA, 64'h0);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if (dma_r_data !== exp_v) $display("FAIL ident_read_outside_out: got %h want %h", dma_r_data, exp_v);
      else pass_cnt++;
      dma_r_req = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input logic [31:0] ctrl_wr, input logic [31:0] ctrl_exp);
      mmio_write(REG_CTRL, ctrl_wr);
      repeat (600) @(negedge clk);
      mmio_issue(REG_CTRL, ctrl_exp);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL %s_ctrl: got %h want %h", tag, mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_r_req = 1'b0;
      for (int r = 0; r < 8; r++) begin
         dma_issue(OFF_OUT + 32'(r*8), pack_row(2, r));
         @(negedge clk);
         exp_v = sb_q.pop_front();
         total_cnt++;
         if (dma_r_data !== exp_v) $display("FAIL %s_out_row%0d: got %h want %h", tag, r, dma_r_data, exp_v);
         else pass_cnt++;
      end
      dma_r_req = 1'b0;
   endtask

   task automatic test_wrap();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
         ma[r][c] = 8'h10;
         mb[r][c] = 8'h10;
         mo[r][c] = 8'h77;
      end
      load_all();
      model_run(1'b0, 64);
      run_and_check("wrap", 32'h1, 32'h4);
   endtask

   task automatic test_accumulate();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
         ma[r][c] = (r == c) ? 8'd1 : 8'd0;
         mb[r][c] = 8'h02;
         mo[r][c] = 8'h01;
      end
      load_all();
      model_run(1'b1, 64);
      run_and_check("accum", 32'h3, 32'h6);
      mmio_write(REG_CTRL, 32'h4);
      mmio_issue(REG_CTRL, 32'h0);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL accum_clear: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_r_req = 1'b0;
   endtask

   task automatic test_busy_lockout();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
         ma[r][c] = (r == c) ? 8'd1 : 8'd0;
         mb[r][c] = 8'(r*8 + c) ^ 8'h5A;
         mo[r][c] = 8'h00;
      end
      load_all();
      model_run(1'b0, 64);
      mmio_write(REG_CTRL, 32'h1);
      repeat (10) @(negedge clk);
      dma_write_row(OFF_INA, 64'hFFFF_FFFF_FFFF_FFFF);
      // run_and_check issues a start that is ignored because the run is still busy.
      run_and_check("busy", 32'h1, 32'hC);
      mmio_write(REG_CTRL, 32'h8);
      mmio_issue(REG_CTRL, 32'h4);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL busy_err_clear: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_r_req = 1'b0;
   endtask

   task automatic test_abort();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
         ma[r][c] = 8'(r + c + 1);
         mb[r][c] = 8'(r*8 + c);
         mo[r][c] = 8'h55;
      end
      load_all();
      model_run(1'b0, 2);
      mmio_write(REG_CTRL, 32'h1);
      repeat (18) @(negedge clk);
      mmio_issue(REG_CTRL, 32'h1);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL abort_running_before: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_w_req  = 1'b1;
      mmio_w_addr = REG_CTRL;
      mmio_w_data = 32'h0;
      mmio_issue(REG_CTRL, 32'h1);
      @(negedge clk);
      mmio_w_req = 1'b0;
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL abort_same_cycle: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_issue(REG_CTRL, 32'h0);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL abort_ctrl_after: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_issue(REG_CNT, 32'd576);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL abort_count_kept: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_r_req = 1'b0;
      for (int r = 0; r < 8; r++) begin
         dma_issue(OFF_OUT + 32'(r*8), pack_row(2, r));
         @(negedge clk);
         exp_v = sb_q.pop_front();
         total_cnt++;
         if (dma_r_data !== exp_v) $display("FAIL abort_out_row%0d: got %h want %h", r, dma_r_data, exp_v);
         else pass_cnt++;
      end
      dma_r_req = 1'b0;
   endtask

   task automatic test_async_reset();
      model_run(1'b0, 3);
      mmio_write(REG_CTRL, 32'h1);
      repeat (29) @(negedge clk);
      dma_issue(OFF_OUT + 32'd56, pack_row(2, 7));
      mmio_issue(REG_CTRL, 32'h1);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if (dma_r_data !== exp_v) $display("FAIL areset_pre_dma: got %h want %h", dma_r_data, exp_v);
      else pass_cnt++;
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL areset_pre_ctrl: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if (dma_r_data !== 64'h0) $display("FAIL areset_dma_now: got %h want 0", dma_r_data);
      else pass_cnt++;
      total_cnt++;
      if (mmio_r_data !== 32'h0) $display("FAIL areset_mmio_now: got %h want 0", mmio_r_data);
      else pass_cnt++;
      total_cnt++;
      if (dut.running_r !== 1'b0) $display("FAIL areset_running_now: got %b want 0", dut.running_r);
      else pass_cnt++;
      dma_r_req  = 1'b0;
      mmio_r_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      mmio_issue(REG_CTRL, 32'h0);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL areset_ctrl_after: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_issue(REG_CNT, 32'h0);
      @(negedge clk);
      exp_v = sb_q.pop_front();
      total_cnt++;
      if ({32'h0, mmio_r_data} !== exp_v) $display("FAIL areset_count_after: got %h want %h", mmio_r_data, exp_v);
      else pass_cnt++;
      mmio_r_req = 1'b0;
      for (int r = 0; r < 8; r++) begin
         dma_issue(OFF_OUT + 32'(r*8), pack_row(2, r));
         @(negedge clk);
         exp_v = sb_q.pop_front();
         total_cnt++;
         if (dma_r_data !== exp_v) $display("FAIL areset_out_row%0d: got %h want %h", r, dma_r_data, exp_v);
         else pass_cnt++;
      end
      dma_r_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_wrap();
      test_accumulate();
      test_busy_lockout();
      test_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
